issue_lsu_ageq: RTL

ISSUE_LSU_AGEQ -- requirements
Module: issue_lsu_ageq

---
 rtl/issue_lsu_ageq_if.sv | 68 ++++++
 rtl/issue_lsu_ageq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_lsu_ageq_if.sv
// rtl/issue_lsu_ageq_if.sv - dispatch, CDB and issue-port bundle for the LSU age-ordered issue queue
interface issue_lsu_ageq_if #(
    parameter int RS_DEPTH = 8,
    parameter int DISP_W   = 4,
    parameter int CDB_W    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int SB_W     = 4,
    parameter int UOP_W    = 16
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    logic [DISP_W-1:0] dispatch_valid;
    logic [UOP_W-1:0]  dispatch_op       [DISP_W];
    logic              dispatch_is_store [DISP_W];
    logic [TAG_W-1:0]  dispatch_dst      [DISP_W];
    logic [TAG_W-1:0]  dispatch_q1       [DISP_W];
    logic [TAG_W-1:0]  dispatch_q2       [DISP_W];
    logic [DATA_W-1:0] dispatch_v1       [DISP_W];
    logic [DATA_W-1:0] dispatch_v2       [DISP_W];
    logic              dispatch_r1       [DISP_W];
    logic              dispatch_r2       [DISP_W];
    logic [SB_W-1:0]   dispatch_sb_id    [DISP_W];
    logic              dispatch_ready;
    logic [CNT_W-1:0]  free_count_o;

    logic [CDB_W-1:0]  cdb_valid;
    logic [TAG_W-1:0]  cdb_tag [CDB_W];
    logic [DATA_W-1:0] cdb_val [CDB_W];

    logic              ld_valid;
    logic              ld_ready;
    logic [UOP_W-1:0]  ld_uop;
    logic [DATA_W-1:0] ld_v1;
    logic [DATA_W-1:0] ld_v2;
    logic [TAG_W-1:0]  ld_dst;
    logic [SB_W-1:0]   ld_sb_id;

    logic              st_valid;
    logic              st_ready;
    logic [UOP_W-1:0]  st_uop;
    logic [DATA_W-1:0] st_v1;
    logic [DATA_W-1:0] st_v2;
    logic [TAG_W-1:0]  st_dst;
    logic [SB_W-1:0]   st_sb_id;

    // Upstream side: dispatch stage, CDB and the two memory ports' ready
    modport master (
        output dispatch_valid, dispatch_op, dispatch_is_store, dispatch_dst,
               dispatch_q1, dispatch_q2, dispatch_v1, dispatch_v2,
               dispatch_r1, dispatch_r2, dispatch_sb_id,
               cdb_valid, cdb_tag, cdb_val, ld_ready, st_ready,
        input  dispatch_ready, free_count_o,
               ld_valid, ld_uop, ld_v1, ld_v2, ld_dst, ld_sb_id,
               st_valid, st_uop, st_v1, st_v2, st_dst, st_sb_id
    );

    // Queue side
    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_is_store, dispatch_dst,
               dispatch_q1, dispatch_q2, dispatch_v1, dispatch_v2,
               dispatch_r1, dispatch_r2, dispatch_sb_id,
               cdb_valid, cdb_tag, cdb_val, ld_ready, st_ready,
        output dispatch_ready, free_count_o,
               ld_valid, ld_uop, ld_v1, ld_v2, ld_dst, ld_sb_id,
               st_valid, st_uop, st_v1, st_v2, st_dst, st_sb_id
    );
endinterface

// File: rtl/issue_lsu_ageq.sv
// rtl/issue_lsu_ageq.sv - load/store issue queue with age matrix, CDB wakeup and in-order stores
module issue_lsu_ageq #(
    parameter int RS_DEPTH = 8,
    parameter int DISP_W   = 4,
    parameter int CDB_W    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int SB_W     = 4,
    parameter int UOP_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    issue_lsu_ageq_if.slave bus
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    // Entry storage; r_older[i][j]=1 means entry j is older than entry i
    logic [RS_DEPTH-1:0] r_busy, r_is_store, r_r1, r_r2;
    logic [UOP_W-1:0]    r_op    [RS_DEPTH];
    logic [TAG_W-1:0]    r_dst   [RS_DEPTH];
    logic [TAG_W-1:0]    r_q1    [RS_DEPTH];
    logic [TAG_W-1:0]    r_q2    [RS_DEPTH];
    logic [DATA_W-1:0]   r_v1    [RS_DEPTH];
    logic [DATA_W-1:0]   r_v2    [RS_DEPTH];
    logic [SB_W-1:0]     r_sb_id [RS_DEPTH];
    logic [RS_DEPTH-1:0] r_older [RS_DEPTH];

    logic [CNT_W-1:0]    w_free_cnt;
    logic                w_disp_ready, w_accept;
    logic [RS_DEPTH-1:0] w_slot_oh [DISP_W];
    logic [DISP_W-1:0]   w_byp1, w_byp2;
    logic [DATA_W-1:0]   w_byp_v1 [DISP_W];
    logic [DATA_W-1:0]   w_byp_v2 [DISP_W];
    logic [RS_DEPTH-1:0] w_alloc, w_new_st, w_new_r1, w_new_r2;
    logic [UOP_W-1:0]    w_new_op  [RS_DEPTH];
    logic [TAG_W-1:0]    w_new_dst [RS_DEPTH];
    logic [TAG_W-1:0]    w_new_q1  [RS_DEPTH];
    logic [TAG_W-1:0]    w_new_q2  [RS_DEPTH];
    logic [DATA_W-1:0]   w_new_v1  [RS_DEPTH];
    logic [DATA_W-1:0]   w_new_v2  [RS_DEPTH];
    logic [SB_W-1:0]     w_new_sb  [RS_DEPTH];
    logic [RS_DEPTH-1:0] w_new_older [RS_DEPTH];
    logic [RS_DEPTH-1:0] w_hit1, w_hit2;
    logic [DATA_W-1:0]   w_wk_v1 [RS_DEPTH];
    logic [DATA_W-1:0]   w_wk_v2 [RS_DEPTH];
    logic [RS_DEPTH-1:0] w_ld_elig, w_st_elig, w_ld_sel, w_st_sel, w_free_mask;

    // Free-entry popcount; everything downstream of it is registered state only
    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_free_cnt = w_free_cnt + CNT_W'(!r_busy[i]);
        end
    end

    assign w_disp_ready      = (w_free_cnt >= CNT_W'(DISP_W));
    assign w_accept          = w_disp_ready && !flush_i;
    assign bus.dispatch_ready = w_disp_ready;
    assign bus.free_count_o   = w_free_cnt;

    // Pack valid slots, in slot order, onto the lowest entries free before this edge
    always_comb begin
        logic [RS_DEPTH-1:0] avail;
        logic                found;
        avail = ~r_busy;
        for (int s = 0; s < DISP_W; s++) begin
            w_slot_oh[s] = '0;
            found        = 1'b0;
            if (w_accept && bus.dispatch_valid[s]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (!found && avail[i]) begin
                        w_slot_oh[s][i] = 1'b1;
                        avail[i]        = 1'b0;
                        found           = 1'b1;
                    end
                end
            end
        end
    end

    // Same-cycle CDB bypass for dispatching sources; lowest CDB port wins on duplicate tags
    always_comb begin
        for (int s = 0; s < DISP_W; s++) begin
            w_byp1[s]   = 1'b0;
            w_byp2[s]   = 1'b0;
            w_byp_v1[s] = '0;
            w_byp_v2[s] = '0;
            for (int c = CDB_W - 1; c >= 0; c--) begin
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.dispatch_q1[s]) begin
                    w_byp1[s]   = 1'b1;
                    w_byp_v1[s] = bus.cdb_val[c];
                end
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.dispatch_q2[s]) begin
                    w_byp2[s]   = 1'b1;
                    w_byp_v2[s] = bus.cdb_val[c];
                end
            end
        end
    end

    // Route each slot's payload to its entry; age row = busy entries plus lower-slot siblings
    always_comb begin
        logic [RS_DEPTH-1:0] lower;
        lower    = '0;
        w_alloc  = '0;
        w_new_st = '0;
        w_new_r1 = '0;
        w_new_r2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_new_op[i]    = '0;
            w_new_dst[i]   = '0;
            w_new_q1[i]    = '0;
            w_new_q2[i]    = '0;
            w_new_v1[i]    = '0;
            w_new_v2[i]    = '0;
            w_new_sb[i]    = '0;
            w_new_older[i] = '0;
        end
        for (int s = 0; s < DISP_W; s++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_slot_oh[s][i]) begin
                    w_alloc[i]     = 1'b1;
                    w_new_st[i]    = bus.dispatch_is_store[s];
                    w_new_op[i]    = bus.dispatch_op[s];
                    w_new_dst[i]   = bus.dispatch_dst[s];
                    w_new_q1[i]    = bus.dispatch_q1[s];
                    w_new_q2[i]    = bus.dispatch_q2[s];
                    w_new_sb[i]    = bus.dispatch_sb_id[s];
                    w_new_r1[i]    = bus.dispatch_r1[s] | w_byp1[s];
                    w_new_r2[i]    = bus.dispatch_r2[s] | w_byp2[s];
                    w_new_v1[i]    = (!bus.dispatch_r1[s] && w_byp1[s]) ? w_byp_v1[s] : bus.dispatch_v1[s];
                    w_new_v2[i]    = (!bus.dispatch_r2[s] && w_byp2[s]) ? w_byp_v2[s] : bus.dispatch_v2[s];
                    w_new_older[i] = r_busy | lower;
                end
            end
            lower = lower | w_slot_oh[s];
        end
    end

    // CDB tag match against resident source tags
    always_comb begin
        w_hit1 = '0;
        w_hit2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wk_v1[i] = '0;
            w_wk_v2[i] = '0;
            for (int c = CDB_W - 1; c >= 0; c--) begin
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == r_q1[i]) begin
                    w_hit1[i]  = 1'b1;
                    w_wk_v1[i] = bus.cdb_val[c];
                end
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == r_q2[i]) begin
                    w_hit2[i]  = 1'b1;
                    w_wk_v2[i] = bus.cdb_val[c];
                end
            end
        end
    end

    // Eligibility and oldest-first pick per port; nothing may pass a busy older store
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            logic old_store;
            old_store    = |(r_older[i] & r_busy & r_is_store);
            w_ld_elig[i] = r_busy[i] & ~r_is_store[i] & r_r1[i] & ~old_store;
            w_st_elig[i] = r_busy[i] & r_is_store[i] & r_r1[i] & r_r2[i] & ~old_store;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ld_sel[i] = w_ld_elig[i] & ~|(r_older[i] & w_ld_elig);
            w_st_sel[i] = w_st_elig[i] & ~|(r_older[i] & w_st_elig);
        end
        w_free_mask = (w_ld_sel & {RS_DEPTH{bus.ld_ready}}) | (w_st_sel & {RS_DEPTH{bus.st_ready}});
    end

    assign bus.ld_valid = |w_ld_sel;
    assign bus.st_valid = |w_st_sel;

    // One-hot payload mux for both issue ports; zero when nothing is selected
    always_comb begin
        bus.ld_uop = '0; bus.ld_v1 = '0; bus.ld_v2 = '0; bus.ld_dst = '0; bus.ld_sb_id = '0;
        bus.st_uop = '0; bus.st_v1 = '0; bus.st_v2 = '0; bus.st_dst = '0; bus.st_sb_id = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_ld_sel[i]) begin
                bus.ld_uop   = r_op[i];
                bus.ld_v1    = r_v1[i];
                bus.ld_v2    = r_v2[i];
                bus.ld_dst   = r_dst[i];
                bus.ld_sb_id = r_sb_id[i];
            end
            if (w_st_sel[i]) begin
                bus.st_uop   = r_op[i];
                bus.st_v1    = r_v1[i];
                bus.st_v2    = r_v2[i];
                bus.st_dst   = r_dst[i];
                bus.st_sb_id = r_sb_id[i];
            end
        end
    end

    // Entry state update: flush, allocate, or free/age-clear/wakeup of resident entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_is_store <= '0;
            r_r1       <= '0;
            r_r2       <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_op[i]    <= '0;
                r_dst[i]   <= '0;
                r_q1[i]    <= '0;
                r_q2[i]    <= '0;
                r_v1[i]    <= '0;
                r_v2[i]    <= '0;
                r_sb_id[i] <= '0;
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (flush_i) begin
                    r_busy[i]  <= 1'b0;
                    r_older[i] <= '0;
                end else if (w_alloc[i]) begin
                    r_busy[i]     <= 1'b1;
                    r_is_store[i] <= w_new_st[i];
                    r_op[i]       <= w_new_op[i];
                    r_dst[i]      <= w_new_dst[i];
                    r_q1[i]       <= w_new_q1[i];
                    r_q2[i]       <= w_new_q2[i];
                    r_v1[i]       <= w_new_v1[i];
                    r_v2[i]       <= w_new_v2[i];
                    r_r1[i]       <= w_new_r1[i];
                    r_r2[i]       <= w_new_r2[i];
                    r_sb_id[i]    <= w_new_sb[i];
                    r_older[i]    <= w_new_older[i] & ~w_free_mask;
                end else begin
                    if (w_free_mask[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                    r_older[i] <= r_older[i] & ~w_free_mask;
                    if (r_busy[i] && !r_r1[i] && w_hit1[i]) begin
                        r_v1[i] <= w_wk_v1[i];
                        r_r1[i] <= 1'b1;
                    end
                    if (r_busy[i] && !r_r2[i] && w_hit2[i]) begin
                        r_v2[i] <= w_wk_v2[i];
                        r_r2[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
